// File: rtl/blake2s_pkg.sv
// Shared constants, widths and the framer state encoding for the BLAKE2s front end.
package blake2s_pkg;

  localparam int BLOCK_BYTES = 64;
  localparam int KK_MAX      = 32;
  localparam int NN_MAX      = 32;

  localparam int IDX_W = 6;
  localparam int KK_W  = 6;
  localparam int NN_W  = 6;
  localparam int CNT_W = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } framer_state_e;

  function automatic logic params_bad(input logic [KK_W-1:0] kk, input logic [NN_W-1:0] nn);
    return (kk > KK_W'(KK_MAX)) || (nn == '0) || (nn > NN_W'(NN_MAX));
  endfunction

endpackage

// File: rtl/blake2s_block_buf.sv
// One-block (64x8) staging buffer: append-only write port, registered read with
// zero padding beyond the written length, and a fill count that can be forced full.
module blake2s_block_buf
  import blake2s_pkg::*;
(
  input  logic             clk,
  input  logic             nreset,
  input  logic             i_clr,
  input  logic             i_wr_en,
  input  logic [7:0]       i_wr_data,
  input  logic             i_seal,
  input  logic             i_rd_en,
  input  logic [IDX_W-1:0] i_rd_addr,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_full,
  output logic [7:0]       o_rd_data
);

  logic [7:0]       r_mem [BLOCK_BYTES];
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_len;
  logic [7:0]       r_rd_q;
  logic             r_rd_pad;
  logic             w_full;
  logic             w_wr;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_full    = (r_cnt == CNT_W'(BLOCK_BYTES));
  assign w_wr      = i_wr_en && !w_full;
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_cnt[IDX_W-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    r_rd_q <= r_mem[i_rd_addr];
  end

  // r_len tracks real bytes; r_cnt may be forced to 64 once a key is complete
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_cnt    <= '0;
      r_len    <= '0;
      r_rd_pad <= 1'b1;
    end else begin
      if (i_clr) begin
        r_cnt <= '0;
        r_len <= '0;
      end else if (w_wr) begin
        r_len <= w_cnt_inc;
        r_cnt <= i_seal ? CNT_W'(BLOCK_BYTES) : w_cnt_inc;
      end else if (i_seal) begin
        r_cnt <= CNT_W'(BLOCK_BYTES);
      end
      r_rd_pad <= !i_rd_en || ({1'b0, i_rd_addr} >= r_len);
    end
  end

  assign o_cnt     = r_cnt;
  assign o_full    = w_full;
  assign o_rd_data = r_rd_pad ? 8'h00 : r_rd_q;

endmodule

// File: rtl/blake2s_msg_framer.sv
// Byte stream to 64-byte block framer for the BLAKE2s core (key block, padding, length).
// Optional sticky protocol error output err_o when BLAKE2S_FRAMER_ERR_EN is defined.
module blake2s_msg_framer
  import blake2s_pkg::*;
#(
  parameter int LL_W = 64
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             start_i,
  input  logic [KK_W-1:0]  kk_i,
  input  logic [NN_W-1:0]  nn_i,
  input  logic             valid_i,
  input  logic [7:0]       data_i,
  input  logic             end_i,
  output logic             ready_o,
  input  logic             core_ready_i,
  output logic [KK_W-1:0]  kk_o,
  output logic [NN_W-1:0]  nn_o,
  output logic [LL_W-1:0]  ll_o,
  output logic             data_v_o,
  output logic [7:0]       data_o,
  output logic [IDX_W-1:0] data_idx_o,
  output logic             block_first_o,
  output logic             block_last_o
`ifdef BLAKE2S_FRAMER_ERR_EN
  ,
  output logic             err_o
`endif
);

  framer_state_e    r_state, w_state_next;
  logic [KK_W-1:0]  r_kk, w_kk_next;
  logic [NN_W-1:0]  r_nn, w_nn_next;
  logic [LL_W-1:0]  r_ll, w_ll_next;
  logic             r_first_pend, w_first_pend_next;
  logic             r_key_phase, w_key_phase_next;
  logic             r_last, w_last_next;
  logic [IDX_W-1:0] r_idx, w_idx_next;

  logic             r_data_v;
  logic [IDX_W-1:0] r_idx_o;
  logic             r_first_o;
  logic             r_last_o;

  logic             w_clr;
  logic             w_wr_en;
  logic             w_seal;
  logic             w_rd_en;
  logic [CNT_W-1:0] w_cnt;
  logic             w_full;
  logic [7:0]       w_rd_data;

  blake2s_block_buf u_buf (
    .clk       (clk),
    .nreset    (nreset),
    .i_clr     (w_clr),
    .i_wr_en   (w_wr_en),
    .i_wr_data (data_i),
    .i_seal    (w_seal),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_idx),
    .o_cnt     (w_cnt),
    .o_full    (w_full),
    .o_rd_data (w_rd_data)
  );

  assign ready_o = (r_state == FILL) && !w_full;

  always_comb begin
    w_state_next      = r_state;
    w_kk_next         = r_kk;
    w_nn_next         = r_nn;
    w_ll_next         = r_ll;
    w_first_pend_next = r_first_pend;
    w_key_phase_next  = r_key_phase;
    w_last_next       = r_last;
    w_idx_next        = r_idx;
    w_clr             = 1'b0;
    w_wr_en           = 1'b0;
    w_seal            = 1'b0;
    w_rd_en           = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_kk_next         = kk_i;
          w_nn_next         = nn_i;
          w_ll_next         = '0;
          w_clr             = 1'b1;
          w_first_pend_next = 1'b1;
          w_key_phase_next  = (kk_i != '0);
          w_last_next       = 1'b0;
          w_idx_next        = '0;
          w_state_next      = FILL;
        end
      end
      FILL: begin
        // end_i wins over a coincident byte, which is then dropped
        if (end_i) begin
          w_last_next  = 1'b1;
          w_state_next = WAIT;
        end else if (valid_i && w_full) begin
          w_last_next  = 1'b0;
          w_state_next = WAIT;
        end else if (valid_i) begin
          w_wr_en = 1'b1;
          if (r_key_phase) begin
            if ((w_cnt + CNT_W'(1)) == {1'b0, r_kk}) begin
              w_seal           = 1'b1;
              w_key_phase_next = 1'b0;
            end
          end else begin
            w_ll_next = r_ll + LL_W'(1);
          end
        end
      end
      WAIT: begin
        if (core_ready_i) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        w_rd_en    = 1'b1;
        w_idx_next = r_idx + IDX_W'(1);
        if (r_idx == '1) begin
          w_clr             = 1'b1;
          w_first_pend_next = 1'b0;
          w_state_next      = r_last ? IDLE : FILL;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state      <= IDLE;
      r_kk         <= '0;
      r_nn         <= '0;
      r_ll         <= '0;
      r_first_pend <= 1'b0;
      r_key_phase  <= 1'b0;
      r_last       <= 1'b0;
      r_idx        <= '0;
    end else begin
      r_state      <= w_state_next;
      r_kk         <= w_kk_next;
      r_nn         <= w_nn_next;
      r_ll         <= w_ll_next;
      r_first_pend <= w_first_pend_next;
      r_key_phase  <= w_key_phase_next;
      r_last       <= w_last_next;
      r_idx        <= w_idx_next;
    end
  end

  // Block outputs are registered alongside the buffer's registered read
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_data_v  <= 1'b0;
      r_idx_o   <= '0;
      r_first_o <= 1'b0;
      r_last_o  <= 1'b0;
    end else begin
      r_data_v  <= (r_state == DRAIN);
      r_idx_o   <= (r_state == DRAIN) ? r_idx : '0;
      r_first_o <= (r_state == DRAIN) && r_first_pend;
      r_last_o  <= (r_state == DRAIN) && r_last;
    end
  end

  assign kk_o          = r_kk;
  assign nn_o          = r_nn;
  assign ll_o          = r_ll;
  assign data_v_o      = r_data_v;
  assign data_o        = w_rd_data;
  assign data_idx_o    = r_idx_o;
  assign block_first_o = r_first_o;
  assign block_last_o  = r_last_o;

`ifdef BLAKE2S_FRAMER_ERR_EN
  logic r_err;
  logic w_err_next;

  always_comb begin
    w_err_next = r_err;
    if ((r_state == IDLE) && start_i) begin
      w_err_next = params_bad(kk_i, nn_i);
    end
    if ((valid_i && (r_state == IDLE)) || (start_i && (r_state != IDLE)) || (valid_i && end_i)) begin
      w_err_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_err_next;
    end
  end

  assign err_o = r_err;
`endif

endmodule

// File: tb/tb_blake2s_msg_framer.sv
// Scoreboard bench for blake2s_msg_framer: expected block beats are queued as
// stimulus is driven and compared as the framer emits them.
module tb_blake2s_msg_framer;

  logic        clk;
  logic        nreset;
  logic        start_i;
  logic [5:0]  kk_i;
  logic [5:0]  nn_i;
  logic        valid_i;
  logic [7:0]  data_i;
  logic        end_i;
  logic        ready_o;
  logic        core_ready_i;
  logic [5:0]  kk_o;
  logic [5:0]  nn_o;
  logic [63:0] ll_o;
  logic        data_v_o;
  logic [7:0]  data_o;
  logic [5:0]  data_idx_o;
  logic        block_first_o;
  logic        block_last_o;
`ifdef BLAKE2S_FRAMER_ERR_EN
  logic        err_o;
`endif

  blake2s_msg_framer #(.LL_W(64)) dut (
    .clk           (clk),
    .nreset        (nreset),
    .start_i       (start_i),
    .kk_i          (kk_i),
    .nn_i          (nn_i),
    .valid_i       (valid_i),
    .data_i        (data_i),
    .end_i         (end_i),
    .ready_o       (ready_o),
    .core_ready_i  (core_ready_i),
    .kk_o          (kk_o),
    .nn_o          (nn_o),
    .ll_o          (ll_o),
    .data_v_o      (data_v_o),
    .data_o        (data_o),
    .data_idx_o    (data_idx_o),
    .block_first_o (block_first_o),
    .block_last_o  (block_last_o)
`ifdef BLAKE2S_FRAMER_ERR_EN
    ,
    .err_o         (err_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       first;
    logic       last;
    logic [5:0] idx;
    logic [7:0] data;
  } beat_t;

  beat_t      sb[$];
  logic [7:0] blk[$];
  int         checks = 0;
  int         errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (nreset && data_v_o) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_beat", {block_first_o, block_last_o, data_idx_o, data_o}, 16'hFFFF);
      end else begin
        e = sb.pop_front();
        check_eq("beat", {block_first_o, block_last_o, data_idx_o, data_o}, e);
        if (data_idx_o == 6'd63)
          $display("block out: first=%0b last=%0b ll=%0d", block_first_o, block_last_o, ll_o);
      end
    end
  end

  // Expand blk (zero padded to 64) into expected beats
  task automatic push_block(input logic first, input logic last);
    beat_t e;
    for (int i = 0; i < 64; i++) begin
      e.first = first;
      e.last  = last;
      e.idx   = 6'(i);
      e.data  = (i < blk.size()) ? blk[i] : 8'h00;
      sb.push_back(e);
    end
    blk.delete();
  endtask

  task automatic do_start(input logic [5:0] kk, input logic [5:0] nn);
    @(posedge clk); #1;
    start_i = 1'b1; kk_i = kk; nn_i = nn;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit acc;
    int n;
    valid_i = 1'b1; data_i = b; acc = 1'b0; n = 0;
    while (!acc && n < 500) begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk); #1;
      n++;
    end
    valid_i = 1'b0;
    check_eq("send_accept", 64'(acc), 64'd1);
  endtask

  // Returns #1 after the edge that samples end_i
  task automatic do_end();
    end_i = 1'b1;
    @(posedge clk); #1;
    end_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || data_v_o) && n < 1000) begin
      @(posedge clk); #2;
      n++;
    end
    check_eq("drain_done", {62'd0, sb.size() != 0, data_v_o}, 64'd0);
  endtask

  initial begin
    bit found;
    int n;
    nreset = 1'b0; start_i = 1'b0; kk_i = '0; nn_i = '0;
    valid_i = 1'b0; data_i = '0; end_i = 1'b0; core_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", 64'(ready_o), 0);
    check_eq("rst_data_v", 64'(data_v_o), 0);
    check_eq("rst_data", 64'(data_o), 0);
    check_eq("rst_idx", 64'(data_idx_o), 0);
    check_eq("rst_first_last", {62'd0, block_first_o, block_last_o}, 0);
    check_eq("rst_kk_nn", {52'd0, kk_o, nn_o}, 0);
    check_eq("rst_ll", ll_o, 0);
    nreset = 1'b1;

    // "abc", unkeyed: single padded block, latency 2 from end_i
    do_start(6'd0, 6'd32);
    blk = '{8'h61, 8'h62, 8'h63};
    push_block(1'b1, 1'b1);
    send_byte(8'h61); send_byte(8'h62); send_byte(8'h63);
    do_end();
    @(negedge clk); check_eq("lat0", 64'(data_v_o), 0);
    @(negedge clk); check_eq("lat1", 64'(data_v_o), 0);
    @(negedge clk); check_eq("lat2", 64'(data_v_o), 1);
    wait_drain();
    check_eq("abc_ll", ll_o, 64'd3);
    check_eq("abc_kk_nn", {52'd0, kk_o, nn_o}, {52'd0, 6'd0, 6'd32});

    // Empty message: one all-zero block
    do_start(6'd0, 6'd32);
    push_block(1'b1, 1'b1);
    do_end();
    wait_drain();
    check_eq("empty_ll", ll_o, 64'd0);

    // Exactly 64 bytes: block held until end_i
    do_start(6'd0, 6'd16);
    for (int i = 0; i < 64; i++) blk.push_back(8'((i * 7 + 5) & 8'hFF));
    push_block(1'b1, 1'b1);
    for (int i = 0; i < 64; i++) send_byte(8'((i * 7 + 5) & 8'hFF));
    repeat (20) @(negedge clk);
    check_eq("held_data_v", 64'(data_v_o), 0);
    check_eq("held_ready", 64'(ready_o), 0);
    do_end();
    wait_drain();
    check_eq("b64_ll", ll_o, 64'd64);
    check_eq("b64_nn", 64'(nn_o), 64'd16);

    // 65 bytes: two blocks, second holds the last byte at idx0
    do_start(6'd0, 6'd32);
    for (int i = 0; i < 64; i++) blk.push_back(8'(i + 8'h80));
    push_block(1'b1, 1'b0);
    blk.push_back(8'h3C);
    push_block(1'b0, 1'b1);
    for (int i = 0; i < 64; i++) send_byte(8'(i + 8'h80));
    send_byte(8'h3C);
    do_end();
    wait_drain();
    check_eq("b65_ll", ll_o, 64'd65);

    // Keyed: key block then message block
    do_start(6'd4, 6'd32);
    blk = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    push_block(1'b1, 1'b0);
    blk = '{8'h11, 8'h22};
    push_block(1'b0, 1'b1);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    send_byte(8'h11); send_byte(8'h22);
    do_end();
    wait_drain();
    check_eq("key_ll", ll_o, 64'd2);
    check_eq("key_kk", 64'(kk_o), 64'd4);

    // Core backpressure in WAIT
    do_start(6'd0, 6'd32);
    blk = '{8'h5A};
    push_block(1'b1, 1'b1);
    send_byte(8'h5A);
    core_ready_i = 1'b0;
    do_end();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("wait_data_v", 64'(data_v_o), 0);
      check_eq("wait_ready", 64'(ready_o), 0);
    end
    @(posedge clk); #1;
    core_ready_i = 1'b1;
    @(negedge clk); check_eq("cr_lat0", 64'(data_v_o), 0);
    @(negedge clk); check_eq("cr_lat1", 64'(data_v_o), 0);
    @(negedge clk); check_eq("cr_lat2", 64'(data_v_o), 1);
    wait_drain();

    // Reset in the middle of DRAIN
    do_start(6'd0, 6'd32);
    blk = '{8'h01, 8'h02, 8'h03};
    push_block(1'b1, 1'b1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    do_end();
    found = 1'b0; n = 0;
    while (!found && n < 300) begin
      @(negedge clk);
      if (data_v_o && data_idx_o == 6'd30) found = 1'b1;
      n++;
    end
    check_eq("reach_idx30", 64'(found), 64'd1);
    #1 nreset = 1'b0;
    #1;
    check_eq("abort_data_v", 64'(data_v_o), 0);
    check_eq("abort_data", 64'(data_o), 0);
    check_eq("abort_idx", 64'(data_idx_o), 0);
    check_eq("abort_first_last", {62'd0, block_first_o, block_last_o}, 0);
    check_eq("abort_kk_nn_ll", {52'd0, kk_o, nn_o} | ll_o, 0);
    check_eq("abort_ready", 64'(ready_o), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;

    // Clean run after the abort
    do_start(6'd8, 6'd20);
    blk = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
    push_block(1'b1, 1'b0);
    blk = '{8'hC0, 8'hC1};
    push_block(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) send_byte(8'(8'hA0 + i));
    send_byte(8'hC0); send_byte(8'hC1);
    do_end();
    wait_drain();
    check_eq("post_ll", ll_o, 64'd2);
    check_eq("post_kk_nn", {52'd0, kk_o, nn_o}, {52'd0, 6'd8, 6'd20});

    check_eq("sb_empty", 64'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
